// File: rtl/bcd_counter_chain.sv
// Multi-digit modulo-RADIX up/down counter chain.
// One count step is taken per enabled cycle. The ripple carry between digits
// is resolved combinationally within the same cycle. The block supports
// synchronous clear, clamped parallel load, and either wrap-around or
// one-shot hold at the terminal count. The per-digit wrap pulses, the chain
// carry pulse and the sticky terminal flag are all registered.
module bcd_counter_chain #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  stop_at_tc,
    output logic [4*DIGITS-1:0]   cnt,
    output logic [DIGITS-1:0]     dig_co,
    output logic                  carry,
    output logic                  tc_flag
);

    localparam logic [3:0] DIG_MAX = 4'(RADIX - 1);

    // Any loaded digit that is outside the digit range is stored as the top legal value.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if ({1'b0, d} >= 5'(RADIX)) begin
            return DIG_MAX;
        end else begin
            return d;
        end
    endfunction

    // A digit is at its terminal value in the current counting direction.
    function automatic logic is_term(input logic [3:0] d, input logic dir_up);
        if (dir_up) begin
            return (d == DIG_MAX);
        end else begin
            return (d == 4'd0);
        end
    endfunction

    // Compute the value of a single digit after one step.
    // When counting up, an out-of-range digit also wraps to 0.
    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic dir_up);
        if (dir_up) begin
            if (d >= DIG_MAX) begin
                return 4'd0;
            end else begin
                return d + 4'd1;
            end
        end else begin
            if (d == 4'd0) begin
                return DIG_MAX;
            end else begin
                return d - 4'd1;
            end
        end
    endfunction

    logic [4*DIGITS-1:0] r_cnt;
    logic [DIGITS-1:0]   r_dig_co;
    logic                r_carry;
    logic                r_tc_flag;

    logic [DIGITS:0]     w_chain;      // w_chain[i]: all digits below i are at terminal
    logic [DIGITS-1:0]   w_term;
    logic                w_at_tc;
    logic                w_step;
    logic [4*DIGITS-1:0] w_nxt_cnt;
    logic [DIGITS-1:0]   w_wrap;
    logic                w_nxt_tc;
    logic                w_carry;
    logic [4*DIGITS-1:0] w_load_clamped;

    // Compute the ripple enable chain, the next count, the wrap pulses and the chain carry.
    always_comb begin
        w_chain        = '0;
        w_term         = '0;
        w_nxt_cnt      = r_cnt;
        w_wrap         = '0;
        w_nxt_tc       = 1'b1;
        w_load_clamped = '0;
        w_chain[0]     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_term[i]      = is_term(r_cnt[4*i +: 4], up);
            w_chain[i + 1] = w_chain[i] & w_term[i];
        end
        w_at_tc = w_chain[DIGITS];
        // In hold mode, a counter that is already at the terminal count ignores en.
        w_step  = en & ~(stop_at_tc & w_at_tc);
        for (int i = 0; i < DIGITS; i++) begin
            if (w_step && w_chain[i]) begin
                w_nxt_cnt[4*i +: 4] = step_digit(r_cnt[4*i +: 4], up);
                w_wrap[i]           = w_term[i];
            end else begin
                w_nxt_cnt[4*i +: 4] = r_cnt[4*i +: 4];
                w_wrap[i]           = 1'b0;
            end
            w_nxt_tc                 = w_nxt_tc & is_term(w_nxt_cnt[4*i +: 4], up);
            w_load_clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
        end
        // In hold mode, carry fires when the count arrives at the terminal value.
        // In wrap mode, carry fires when the count leaves the terminal value.
        if (stop_at_tc) begin
            w_carry = w_step & w_nxt_tc;
        end else begin
            w_carry = w_step & w_at_tc;
        end
    end

    // Hold the count, the pulse outputs and the sticky flag. Priority is clr > load > en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_dig_co  <= '0;
            r_carry   <= 1'b0;
            r_tc_flag <= 1'b0;
        end else if (clr) begin
            r_cnt     <= '0;
            r_dig_co  <= '0;
            r_carry   <= 1'b0;
            r_tc_flag <= 1'b0;
        end else if (load) begin
            r_cnt     <= w_load_clamped;
            r_dig_co  <= '0;
            r_carry   <= 1'b0;
            r_tc_flag <= 1'b0;
        end else begin
            r_cnt     <= w_nxt_cnt;
            r_dig_co  <= w_wrap;
            r_carry   <= w_carry;
            r_tc_flag <= r_tc_flag | w_carry;
        end
    end

    assign cnt     = r_cnt;
    assign dig_co  = r_dig_co;
    assign carry   = r_carry;
    assign tc_flag = r_tc_flag;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed, table-driven bench for bcd_counter_chain.
// Instance A uses 2 digits with radix 10. Instance B uses 2 digits with radix 6.
// Both instances share the same stimulus.
module tb_bcd_counter_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, en, up, load, stop_at_tc;
    logic [7:0] load_val;

    logic [7:0] a_cnt;
    logic [1:0] a_dig_co;
    logic       a_carry, a_tc_flag;
    logic [7:0] b_cnt;
    logic [1:0] b_dig_co;
    logic       b_carry, b_tc_flag;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    bcd_counter_chain #(.DIGITS(2), .RADIX(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .stop_at_tc(stop_at_tc),
        .cnt(a_cnt), .dig_co(a_dig_co), .carry(a_carry), .tc_flag(a_tc_flag)
    );

    bcd_counter_chain #(.DIGITS(2), .RADIX(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .stop_at_tc(stop_at_tc),
        .cnt(b_cnt), .dig_co(b_dig_co), .carry(b_carry), .tc_flag(b_tc_flag)
    );

    typedef struct {
        string      name;
        logic       clr, en, up, load, stop;
        logic [7:0] lv;
        logic [7:0] e_cnt;
        logic [1:0] e_co;
        logic       e_carry, e_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic c, input logic e, input logic u,
                       input logic l, input logic s, input logic [7:0] lv,
                       input logic [7:0] ec, input logic [1:0] eco,
                       input logic ecar, input logic etc_f);
        vec_t v;
        v.name = nm; v.clr = c; v.en = e; v.up = u; v.load = l; v.stop = s; v.lv = lv;
        v.e_cnt = ec; v.e_co = eco; v.e_carry = ecar; v.e_tc = etc_f;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic c, input logic e, input logic u,
                          input logic l, input logic s, input logic [7:0] lv);
        clr = c; en = e; up = u; load = l; stop_at_tc = s; load_val = lv;
    endtask

    // Wait for one active edge, then move to a point away from that edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int co0_cnt;
        int car_cnt;
        logic [7:0] exp_v;

        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        #12;
        chk("reset_cnt",   {24'd0, a_cnt},    32'h00);
        chk("reset_co",    {30'd0, a_dig_co}, 32'h0);
        chk("reset_carry", {31'd0, a_carry},  32'h0);
        chk("reset_tc",    {31'd0, a_tc_flag}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: clear, then count up 100 times in wrap mode.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        chk("t1_clr", {24'd0, a_cnt}, 32'h00);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        co0_cnt = 0;
        car_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            exp_v = {4'((k / 10) % 10), 4'(k % 10)};
            chk($sformatf("t1_cnt_k%0d", k), {24'd0, a_cnt}, {24'd0, exp_v});
            if (a_dig_co[0]) co0_cnt++;
            if (a_carry) car_cnt++;
        end
        chk("t1_carry_count", car_cnt, 32'd1);
        chk("t1_co0_count", co0_cnt, 32'd10);
        chk("t1_tc_flag", {31'd0, a_tc_flag}, 32'h1);

        // Table-driven vectors. Expected values apply to instance A (radix 10).
        add("ld_clamp",      0,0,1,1,0, 8'hAF, 8'h99, 2'b00, 0, 0);
        add("clr_ld_en",     1,1,1,1,0, 8'h55, 8'h00, 2'b00, 0, 0);
        add("ld_en_nostep",  0,1,1,1,0, 8'h37, 8'h37, 2'b00, 0, 0);
        add("up_step",       0,1,1,0,0, 8'h00, 8'h38, 2'b00, 0, 0);
        add("en0_hold",      0,0,1,0,0, 8'h00, 8'h38, 2'b00, 0, 0);
        add("ld_19",         0,0,1,1,0, 8'h19, 8'h19, 2'b00, 0, 0);
        add("ripple_19_20",  0,1,1,0,0, 8'h00, 8'h20, 2'b01, 0, 0);
        add("ld_99",         0,0,1,1,0, 8'h99, 8'h99, 2'b00, 0, 0);
        add("wrap_up",       0,1,1,0,0, 8'h00, 8'h00, 2'b11, 1, 1);
        add("idle_sticky",   0,0,1,0,0, 8'h00, 8'h00, 2'b00, 0, 1);
        add("ld_00",         0,0,0,1,0, 8'h00, 8'h00, 2'b00, 0, 0);
        add("wrap_down",     0,1,0,0,0, 8'h00, 8'h99, 2'b11, 1, 1);
        add("ld_03_hold",    0,0,0,1,1, 8'h03, 8'h03, 2'b00, 0, 0);
        add("hold_dn_02",    0,1,0,0,1, 8'h00, 8'h02, 2'b00, 0, 0);
        add("hold_dn_01",    0,1,0,0,1, 8'h00, 8'h01, 2'b00, 0, 0);
        add("hold_dn_00",    0,1,0,0,1, 8'h00, 8'h00, 2'b00, 1, 1);
        add("hold_frozen1",  0,1,0,0,1, 8'h00, 8'h00, 2'b00, 0, 1);
        add("hold_frozen2",  0,1,0,0,1, 8'h00, 8'h00, 2'b00, 0, 1);
        add("ld_tc_hold",    0,0,1,1,1, 8'h99, 8'h99, 2'b00, 0, 0);
        add("tc_ld_frozen",  0,1,1,0,1, 8'h00, 8'h99, 2'b00, 0, 0);
        add("dir_flip_dn",   0,1,0,0,1, 8'h00, 8'h98, 2'b00, 0, 0);
        add("hold_up_99",    0,1,1,0,1, 8'h00, 8'h99, 2'b00, 1, 1);
        add("clr_flags",     1,0,1,0,0, 8'h00, 8'h00, 2'b00, 0, 0);

        foreach (vecs[i]) begin
            set_in(vecs[i].clr, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].stop, vecs[i].lv);
            tick();
            chk({vecs[i].name, "_cnt"},   {24'd0, a_cnt},     {24'd0, vecs[i].e_cnt});
            chk({vecs[i].name, "_co"},    {30'd0, a_dig_co},  {30'd0, vecs[i].e_co});
            chk({vecs[i].name, "_carry"}, {31'd0, a_carry},   {31'd0, vecs[i].e_carry});
            chk({vecs[i].name, "_tc"},    {31'd0, a_tc_flag}, {31'd0, vecs[i].e_tc});
        end

        // Test 5: radix-6 instance.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05);
        tick();
        chk("r6_ld", {24'd0, b_cnt}, 32'h05);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        chk("r6_up_cnt", {24'd0, b_cnt},    32'h10);
        chk("r6_up_co",  {30'd0, b_dig_co}, 32'h1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("r6_dn_cnt", {24'd0, b_cnt}, 32'h05);

        // Test 6: assert the asynchronous reset in the middle of counting, with en held high.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        chk("pre_rst_carry", {31'd0, a_carry}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",   {24'd0, a_cnt},     32'h00);
        chk("arst_co",    {30'd0, a_dig_co},  32'h0);
        chk("arst_carry", {31'd0, a_carry},   32'h0);
        chk("arst_tc",    {31'd0, a_tc_flag}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_cnt", {24'd0, a_cnt}, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
